memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/mem_pkg.sv | 15 +
 rtl/ram_sp.sv | 27 ++
 rtl/memory_responder.sv | 115 +++++++++++
 tb/tb_memory_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared sizing constants and FSM state encoding for the memory responder
package mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/ram_sp.sv
// rtl/ram_sp.sv - single-port synchronous RAM, registered read, no reset on contents
module ram_sp
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int RAM_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    // Read-before-write: rdata returns the old word on a write cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - edge-triggered wait-state memory responder for the control unit
module memory_responder
    import mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = mem_pkg::ADDR_W,
    parameter int DATA_W      = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              memoryRead,
    input  logic              memoryWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              err
);

    localparam logic [2:0] WS_LOAD = WAIT_STATES[2:0];

    state_t            state;
    logic [2:0]        cnt;
    logic              prev_rd;
    logic              prev_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              op_wr;
    logic [DATA_W-1:0] ram_q;
    logic              ram_we;
    logic              rise_rd;
    logic              rise_wr;

    assign rise_rd = memoryRead  & ~prev_rd;
    assign rise_wr = memoryWrite & ~prev_wr;
    assign ram_we  = (state == ST_ACCESS) && op_wr;

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            prev_rd   <= 1'b0;
            prev_wr   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_wr     <= 1'b0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            err       <= 1'b0;
        end else begin
            prev_rd   <= memoryRead;
            prev_wr   <= memoryWrite;
            mem_ready <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Any new edge with both levels high is an illegal combined request.
                    if (rise_rd || rise_wr) begin
                        if (memoryRead && memoryWrite) begin
                            err <= 1'b1;
                        end else begin
                            addr_q   <= address;
                            wdata_q  <= wdata;
                            op_wr    <= rise_wr;
                            mem_busy <= 1'b1;
                            if (WAIT_STATES == 0) begin
                                state <= ST_ACCESS;
                            end else begin
                                state <= ST_WAIT;
                                cnt   <= WS_LOAD;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt <= 3'd1) begin
                        cnt   <= '0;
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    // RAM output sampled at the ACCESS edge is published with the ready pulse.
                    if (!op_wr) begin
                        rdata <= ram_q;
                    end
                    mem_ready <= 1'b1;
                    mem_busy  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed self-checking bench for memory_responder
module tb_memory_responder;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [8:0]  address = '0;
    logic [31:0] wdata = '0;

    logic        rd_a = 1'b0, wr_a = 1'b0;
    logic [31:0] rdata_a;
    logic        ready_a, busy_a, err_a;

    logic        rd_b = 1'b0, wr_b = 1'b0;
    logic [31:0] rdata_b;
    logic        ready_b, busy_b, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_responder #(.WAIT_STATES(2), .ADDR_W(9), .DATA_W(32)) dut_a (
        .clk         (clk),
        .clr         (clr),
        .memoryRead  (rd_a),
        .memoryWrite (wr_a),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata_a),
        .mem_ready   (ready_a),
        .mem_busy    (busy_a),
        .err         (err_a)
    );

    memory_responder #(.WAIT_STATES(0), .ADDR_W(9), .DATA_W(32)) dut_b (
        .clk         (clk),
        .clr         (clr),
        .memoryRead  (rd_b),
        .memoryWrite (wr_b),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata_b),
        .mem_ready   (ready_b),
        .mem_busy    (busy_b),
        .err         (err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request held high for a 10-cycle window starting at the capture edge.
    task automatic txn(input int which, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d,
                       output int lat, output int nbusy, output int nrdy,
                       output int nerr, output logic [31:0] rdv);
        logic b, r, e;
        logic [31:0] q;
        lat = -1; nbusy = 0; nrdy = 0; nerr = 0; rdv = '0;
        @(negedge clk);
        address = a;
        wdata   = d;
        if (which == 0) begin rd_a = rd; wr_a = wr; end
        else            begin rd_b = rd; wr_b = wr; end
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            if (which == 0) begin b = busy_a; r = ready_a; e = err_a; q = rdata_a; end
            else            begin b = busy_b; r = ready_b; e = err_b; q = rdata_b; end
            if (b) nbusy++;
            if (e) nerr++;
            if (r) begin
                nrdy++;
                if (lat < 0) begin lat = k; rdv = q; end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    endtask

    int lat, nbusy, nrdy, nerr;
    logic [31:0] rdv;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata_a", rdata_a, 32'h0);
        chk("reset_ready_a", {31'b0, ready_a}, 32'h0);
        chk("reset_busy_a",  {31'b0, busy_a}, 32'h0);
        chk("reset_err_a",   {31'b0, err_a}, 32'h0);
        chk("reset_rdata_b", rdata_b, 32'h0);
        @(negedge clk);
        clr = 1'b1;

        // Known prior contents for the error and abort tests
        txn(0, 1'b0, 1'b1, 9'h010, 32'hCAFE0010, lat, nbusy, nrdy, nerr, rdv);
        chk("seed010_nrdy", nrdy, 1);
        txn(0, 1'b0, 1'b1, 9'h1FF, 32'h0BADF00D, lat, nbusy, nrdy, nerr, rdv);
        chk("seed1ff_nrdy", nrdy, 1);
        chk("write_keeps_rdata", rdata_a, 32'h0);

        txn(0, 1'b0, 1'b1, 9'h0A4, 32'hDEADBEEF, lat, nbusy, nrdy, nerr, rdv);
        chk("wr0a4_latency", lat, 4);
        chk("wr0a4_busy_cycles", nbusy, 4);
        chk("wr0a4_nrdy", nrdy, 1);
        chk("wr0a4_nerr", nerr, 0);

        txn(0, 1'b1, 1'b0, 9'h0A4, 32'h0, lat, nbusy, nrdy, nerr, rdv);
        chk("rd0a4_latency", lat, 4);
        chk("rd0a4_busy_cycles", nbusy, 4);
        chk("rd0a4_data", rdv, 32'hDEADBEEF);

        txn(0, 1'b1, 1'b1, 9'h010, 32'h11111111, lat, nbusy, nrdy, nerr, rdv);
        chk("both_nerr", nerr, 1);
        chk("both_nrdy", nrdy, 0);
        chk("both_nbusy", nbusy, 0);
        chk("both_rdata_held", rdata_a, 32'hDEADBEEF);

        txn(0, 1'b1, 1'b0, 9'h010, 32'h0, lat, nbusy, nrdy, nerr, rdv);
        chk("rd010_prior", rdv, 32'hCAFE0010);

        txn(0, 1'b1, 1'b0, 9'h001, 32'h0, lat, nbusy, nrdy, nerr, rdv);
        chk("hold_rd_nrdy", nrdy, 1);

        // Drop and re-raise memoryRead mid-transaction with a new address
        @(negedge clk);
        address = 9'h0A4; rd_a = 1'b1;
        @(posedge clk); #1;
        chk("reraise_busy", {31'b0, busy_a}, 32'h1);
        @(negedge clk); rd_a = 1'b0;
        @(negedge clk); rd_a = 1'b1; address = 9'h010;
        nrdy = 0; rdv = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ready_a) begin
                nrdy++;
                rdv = rdata_a;
            end
        end
        @(negedge clk); rd_a = 1'b0;
        chk("reraise_nrdy", nrdy, 1);
        chk("reraise_data", rdv, 32'hDEADBEEF);

        // Reset during WAIT of a write to 0x1FF
        @(negedge clk);
        address = 9'h1FF; wdata = 32'h12345678; wr_a = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy_before", {31'b0, busy_a}, 32'h1);
        @(posedge clk); #2;
        clr = 1'b0;
        #1;
        chk("abort_rdata", rdata_a, 32'h0);
        chk("abort_ready", {31'b0, ready_a}, 32'h0);
        chk("abort_busy",  {31'b0, busy_a}, 32'h0);
        chk("abort_err",   {31'b0, err_a}, 32'h0);
        wr_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        txn(0, 1'b1, 1'b0, 9'h1FF, 32'h0, lat, nbusy, nrdy, nerr, rdv);
        chk("abort_rd1ff_prior", rdv, 32'h0BADF00D);
        chk("abort_rd1ff_latency", lat, 4);

        // Zero wait states, boundary addresses
        txn(1, 1'b0, 1'b1, 9'h000, 32'hA5A5A5A5, lat, nbusy, nrdy, nerr, rdv);
        chk("ws0_wr000_latency", lat, 2);
        chk("ws0_wr000_busy", nbusy, 2);
        txn(1, 1'b0, 1'b1, 9'h1FF, 32'h5A5A5A5A, lat, nbusy, nrdy, nerr, rdv);
        chk("ws0_wr1ff_latency", lat, 2);
        txn(1, 1'b1, 1'b0, 9'h000, 32'h0, lat, nbusy, nrdy, nerr, rdv);
        chk("ws0_rd000_latency", lat, 2);
        chk("ws0_rd000_data", rdv, 32'hA5A5A5A5);
        txn(1, 1'b1, 1'b0, 9'h1FF, 32'h0, lat, nbusy, nrdy, nerr, rdv);
        chk("ws0_rd1ff_data", rdv, 32'h5A5A5A5A);
        chk("ws0_rd1ff_nrdy", nrdy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
